// File: rtl/fp_to_int_cvt_if.sv
// rtl/fp_to_int_cvt_if.sv - operand/result handshake bundle for the float-to-int converter
// unsigned_op exists only when F2I_UNSIGNED_EN is defined.
interface fp_to_int_cvt_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] fp_in;
  logic [2:0]  r_mode;
`ifdef F2I_UNSIGNED_EN
  logic        unsigned_op;
`endif
  logic        out_valid;
  logic        out_ready;
  logic [31:0] int_out;
  logic        invalid;
  logic        inexact;

  modport master (
`ifdef F2I_UNSIGNED_EN
    output unsigned_op,
`endif
    output in_valid, fp_in, r_mode, out_ready,
    input  in_ready, out_valid, int_out, invalid, inexact
  );

  modport slave (
`ifdef F2I_UNSIGNED_EN
    input  unsigned_op,
`endif
    input  in_valid, fp_in, r_mode, out_ready,
    output in_ready, out_valid, int_out, invalid, inexact
  );
endinterface

// File: rtl/fp_to_int_cvt.sv
// rtl/fp_to_int_cvt.sv - serial IEEE-754 single to 32-bit integer converter (IDLE/SHIFT/ROUND/DONE)
// Define F2I_UNSIGNED_EN to add the unsigned_op input and unsigned range handling.
module fp_to_int_cvt (
  input  logic           clk,
  input  logic           rst_n,
  fp_to_int_cvt_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_ROUND = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]  r_state;
  logic [4:0]  r_cnt;
  logic        r_left;
  logic [31:0] r_mag;
  logic        r_guard;
  logic        r_sticky;
  logic        r_sign;
  logic [2:0]  r_rmode;
  logic        r_uns;
  logic        r_special;
  logic [31:0] r_spec_val;
  logic        r_spec_inv;
  logic [31:0] r_int_out;
  logic        r_invalid;
  logic        r_inexact;

  logic        w_sign;
  logic [7:0]  w_exp;
  logic [22:0] w_frac;
  logic [7:0]  w_e;
  logic [7:0]  w_rn;
  logic [4:0]  w_ln;
  logic        w_left;
  logic [4:0]  w_n;
  logic        w_nan;
  logic        w_uns;
  logic        w_special;
  logic        w_spec_inv;
  logic [31:0] w_spec_val;
  logic        w_inx;
  logic        w_inc;
  logic [31:0] w_rounded;
  logic [31:0] w_res;
  logic        w_res_inv;
  logic        w_res_inx;

  assign w_sign = bus.fp_in[31];
  assign w_exp  = bus.fp_in[30:23];
  assign w_frac = bus.fp_in[22:0];
  assign w_e    = (w_exp == 8'd0) ? 8'd1 : w_exp;
  assign w_nan  = (w_exp == 8'hFF) && (w_frac != 23'd0);
  assign w_left = (w_e >= 8'd150);
  assign w_rn   = 8'd150 - w_e;
  // 150 is 22 modulo 32, so the low five exponent bits give e-150 directly for e in 150..158
  assign w_ln   = w_e[4:0] - 5'd22;
  assign w_n    = w_left ? w_ln : ((w_rn > 8'd26) ? 5'd26 : w_rn[4:0]);

`ifdef F2I_UNSIGNED_EN
  assign w_uns = bus.unsigned_op;
`else
  assign w_uns = 1'b0;
`endif

  always_comb begin
    w_special  = 1'b0;
    w_spec_inv = 1'b0;
    w_spec_val = 32'd0;
    if (w_uns) begin
      if (w_nan || (w_e >= 8'd159)) begin
        w_special  = 1'b1;
        w_spec_inv = 1'b1;
        w_spec_val = (w_sign && !w_nan) ? 32'd0 : 32'hFFFF_FFFF;
      end
    end else if (w_nan || (w_e >= 8'd158)) begin
      w_special = 1'b1;
      // -2^31 is the one representable value at this exponent
      if (w_sign && !w_nan && (w_e == 8'd158) && (w_frac == 23'd0)) begin
        w_spec_val = 32'h8000_0000;
      end else begin
        w_spec_inv = 1'b1;
        w_spec_val = (w_sign && !w_nan) ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end
    end
  end

  always_comb begin
    w_inx = r_guard | r_sticky;
    case (r_rmode)
      3'b001:  w_inc = 1'b0;
      3'b010:  w_inc = r_sign & w_inx;
      3'b011:  w_inc = ~r_sign & w_inx;
      3'b100:  w_inc = r_guard;
      default: w_inc = r_guard & (r_sticky | r_mag[0]);
    endcase
    w_rounded = r_mag + {31'd0, w_inc};
    w_res     = w_rounded;
    w_res_inv = 1'b0;
    w_res_inx = w_inx;
    if (r_special) begin
      w_res     = r_spec_val;
      w_res_inv = r_spec_inv;
      w_res_inx = 1'b0;
    end else if (r_uns) begin
      if (r_sign && (w_rounded != 32'd0)) begin
        w_res     = 32'd0;
        w_res_inv = 1'b1;
        w_res_inx = 1'b0;
      end else if (r_sign) begin
        w_res = 32'd0;
      end
    end else if (r_sign) begin
      w_res = 32'd0 - w_rounded;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 5'd0;
      r_left     <= 1'b0;
      r_mag      <= 32'd0;
      r_guard    <= 1'b0;
      r_sticky   <= 1'b0;
      r_sign     <= 1'b0;
      r_rmode    <= 3'd0;
      r_uns      <= 1'b0;
      r_special  <= 1'b0;
      r_spec_val <= 32'd0;
      r_spec_inv <= 1'b0;
      r_int_out  <= 32'd0;
      r_invalid  <= 1'b0;
      r_inexact  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_sign     <= w_sign;
            r_rmode    <= bus.r_mode;
            r_uns      <= w_uns;
            r_mag      <= {8'd0, (w_exp != 8'd0), w_frac};
            r_guard    <= 1'b0;
            r_sticky   <= 1'b0;
            r_left     <= w_left;
            r_cnt      <= w_n;
            r_special  <= w_special;
            r_spec_val <= w_spec_val;
            r_spec_inv <= w_spec_inv;
            r_state    <= (w_special || (w_n == 5'd0)) ? ST_ROUND : ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (r_left) begin
            r_mag <= {r_mag[30:0], 1'b0};
          end else begin
            r_mag    <= {1'b0, r_mag[31:1]};
            r_guard  <= r_mag[0];
            r_sticky <= r_sticky | r_guard;
          end
          r_cnt <= r_cnt - 5'd1;
          if (r_cnt == 5'd1) begin
            r_state <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          r_int_out <= w_res;
          r_invalid <= w_res_inv;
          r_inexact <= w_res_inx;
          r_state   <= ST_DONE;
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.int_out   = r_int_out;
  assign bus.invalid   = r_invalid;
  assign bus.inexact   = r_inexact;

endmodule

// File: tb/tb_fp_to_int_cvt.sv
// tb/tb_fp_to_int_cvt.sv - directed and randomized checks of fp_to_int_cvt against a value-level model
module tb_fp_to_int_cvt;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  int   n_cmp;

  fp_to_int_cvt_if bus ();

  fp_to_int_cvt dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Value-level reference: value = m * 2^(e-150), rounded by comparing the remainder with one half
  function automatic void ref_model(input logic [31:0] fp, input logic [2:0] md,
                                    output logic [31:0] v, output logic inv,
                                    output logic inx, output int lat);
    int     ex;
    int     e;
    int     k;
    longint m;
    longint q;
    longint rem;
    longint half;
    longint r;
    bit     nz;
    bit     up;
    bit     sgn;
    ex  = int'(fp[30:23]);
    sgn = fp[31];
    m   = longint'(fp[22:0]);
    if (ex != 0) m = m + 64'h80_0000;
    e   = (ex == 0) ? 1 : ex;
    inv = 1'b0;
    inx = 1'b0;
    v   = 32'd0;
    if (e >= 158) lat = 1;
    else if (e >= 150) lat = e - 150 + 1;
    else lat = ((150 - e) > 26 ? 26 : (150 - e)) + 1;
    if (ex == 255) begin
      inv = 1'b1;
      v = ((fp[22:0] != 0) || !sgn) ? 32'h7FFF_FFFF : 32'h8000_0000;
      return;
    end
    if (e >= 190) begin
      inv = 1'b1;
      v = sgn ? 32'h8000_0000 : 32'h7FFF_FFFF;
      return;
    end
    if (e >= 150) begin
      q = m << (e - 150);
      rem = 0;
      half = 1;
    end else begin
      k = 150 - e;
      if (k >= 40) begin
        q = 0;
        rem = m;
        half = longint'(1) << 39;
      end else begin
        q = m >> k;
        rem = m - (q << k);
        half = longint'(1) << (k - 1);
      end
    end
    nz = (rem != 0);
    case (md)
      3'd1:    up = 1'b0;
      3'd2:    up = sgn && nz;
      3'd3:    up = !sgn && nz;
      3'd4:    up = (rem >= half);
      default: up = (rem > half) || ((rem == half) && q[0]);
    endcase
    if (up) q = q + 1;
    r = sgn ? -q : q;
    if (r > 64'sd2147483647) begin
      v = 32'h7FFF_FFFF;
      inv = 1'b1;
    end else if (r < -64'sd2147483648) begin
      v = 32'h8000_0000;
      inv = 1'b1;
    end else begin
      v = r[31:0];
      inx = nz;
    end
  endfunction

  task automatic run_op(input logic [31:0] fp, input logic [2:0] md, input int hold,
                        input logic [31:0] exp_v, input logic exp_inv,
                        input logic exp_inx, input int exp_lat);
    int lat;
    n_vec++;
    @(negedge clk);
    chk("in_ready_idle", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1;
    bus.fp_in    = fp;
    bus.r_mode   = md;
    @(posedge clk);
    #1;
    chk("in_ready_busy", {31'd0, bus.in_ready}, 32'd0);
    // keep offering junk while busy; it must not be taken nor disturb the result
    bus.fp_in  = $urandom;
    bus.r_mode = 3'($urandom_range(0, 7));
    lat = 0;
    while (lat < 40) begin
      if (bus.out_valid) break;
      @(posedge clk);
      #1;
      lat++;
    end
    bus.in_valid = 1'b0;
    chk("latency", lat, exp_lat);
    if (!bus.out_valid) return;
    chk("int_out", bus.int_out, exp_v);
    chk("invalid", {31'd0, bus.invalid}, {31'd0, exp_inv});
    chk("inexact", {31'd0, bus.inexact}, {31'd0, exp_inx});
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("hold_int_out", bus.int_out, exp_v);
      chk("hold_flags", {30'd0, bus.invalid, bus.inexact}, {30'd0, exp_inv, exp_inx});
      chk("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("release_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("release_in_ready", {31'd0, bus.in_ready}, 32'd1);
  endtask

  task automatic run_rand(input logic [31:0] fp, input logic [2:0] md, input int hold);
    logic [31:0] v;
    logic        inv;
    logic        inx;
    int          lat;
    ref_model(fp, md, v, inv, inx, lat);
    run_op(fp, md, hold, v, inv, inx, lat);
  endtask

  initial begin
    logic [31:0] fp;
    bit          seen;
    n_vec = 0;
    n_err = 0;
    n_cmp = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.fp_in     = 32'd0;
    bus.r_mode    = 3'd0;
    bus.out_ready = 1'b0;
`ifdef F2I_UNSIGNED_EN
    bus.unsigned_op = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_int_out", bus.int_out, 32'd0);
    chk("rst_flags", {30'd0, bus.invalid, bus.inexact}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    run_op(32'h3FC0_0000, 3'd0, 0, 32'h0000_0002, 1'b0, 1'b1, 24);
    run_op(32'h3FC0_0000, 3'd1, 1, 32'h0000_0001, 1'b0, 1'b1, 24);
    run_op(32'h4020_0000, 3'd0, 0, 32'h0000_0002, 1'b0, 1'b1, 23);
    run_op(32'h4020_0000, 3'd4, 0, 32'h0000_0003, 1'b0, 1'b1, 23);
    run_op(32'hC020_0000, 3'd2, 0, 32'hFFFF_FFFD, 1'b0, 1'b1, 23);
    run_op(32'h4020_0000, 3'd7, 0, 32'h0000_0002, 1'b0, 1'b1, 23);
    run_op(32'hCF00_0000, 3'd0, 0, 32'h8000_0000, 1'b0, 1'b0, 1);
    run_op(32'h4F00_0000, 3'd0, 0, 32'h7FFF_FFFF, 1'b1, 1'b0, 1);
    run_op(32'hFF80_0000, 3'd0, 0, 32'h8000_0000, 1'b1, 1'b0, 1);
    run_op(32'h7FC0_0000, 3'd0, 0, 32'h7FFF_FFFF, 1'b1, 1'b0, 1);
    run_op(32'h8000_0000, 3'd0, 0, 32'h0000_0000, 1'b0, 1'b0, 27);
    run_op(32'h0000_0000, 3'd3, 0, 32'h0000_0000, 1'b0, 1'b0, 27);
    run_op(32'h0000_0001, 3'd3, 0, 32'h0000_0001, 1'b0, 1'b1, 27);
    run_op(32'h8000_0001, 3'd2, 0, 32'hFFFF_FFFF, 1'b0, 1'b1, 27);
    run_op(32'h8000_0001, 3'd1, 0, 32'h0000_0000, 1'b0, 1'b1, 27);
    run_op(32'h4B00_0000, 3'd0, 0, 32'h0080_0000, 1'b0, 1'b0, 1);
    run_op(32'h4EFF_FFFF, 3'd0, 0, 32'h7FFF_FF80, 1'b0, 1'b0, 8);
    run_op(32'hCF00_0001, 3'd0, 0, 32'h8000_0000, 1'b1, 1'b0, 1);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        fp = $urandom;
      end else begin
        fp[31]    = 1'($urandom_range(0, 1));
        fp[30:23] = 8'($urandom_range(100, 165));
        fp[22:0]  = 23'($urandom);
        if (i % 4 == 0) fp[15:0] = 16'd0;
      end
      run_rand(fp, 3'($urandom_range(0, 7)), $urandom_range(0, 2));
    end

    run_op(32'h4020_0000, 3'd4, 5, 32'h0000_0003, 1'b0, 1'b1, 23);

    // reset while a long right shift is in flight
    n_vec++;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.fp_in    = 32'h3FC0_0000;
    bus.r_mode   = 3'd0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("midrst_int_out", bus.int_out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen = 1'b1;
    end
    chk("midrst_no_result", {31'd0, seen}, 32'd0);

    run_rand(32'h3F80_0000, 3'd0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fp_to_int_cvt.md
FP_TO_INT_CVT -- requirements
Module: fp_to_int_cvt

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-002 SHALL have: in_valid  in  1  operand offered; in_ready  out  1  converter can accept.
REQ-003 SHALL have: fp_in  in  32  IEEE-754 single operand; r_mode  in  3  rounding mode (000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101-111 treated as RNE).
REQ-004 SHALL have: out_valid  out  1  result held; out_ready  in  1  consumer takes result.
REQ-005 SHALL have: int_out  out  32  two's-complement result; invalid  out  1  NaN/out-of-range flag; inexact  out  1  discarded fraction nonzero.
REQ-006 SHALL use one clock; reset asynchronous, active-low.

Function
REQ-007 SHALL implement FSM states IDLE, SHIFT, ROUND, DONE.
REQ-008 in_ready SHALL be 1 only in IDLE. Transfer occurs on a cycle with in_valid && in_ready.
REQ-009 On transfer, SHALL latch sign, r_mode and 24-bit mantissa {hidden, frac}. Hidden = (exp != 0). Effective exponent e = max(exp, 1).
REQ-010 Load: e <= 149 → shift right N = min(150-e, 26); 150 <= e <= 157 → shift left N = e-150.
REQ-011 Load, special case NaN (exp=FF, frac!=0) or +Inf or e >= 158 (exception below) → preset int_out 0x7FFFFFFF, invalid=1. -Inf or e >= 158 negative → 0x80000000, invalid=1.
REQ-012 Exception to REQ-011: sign=1, exp=158, frac=0 SHALL yield 0x80000000 with no flags.
REQ-013 Specials, and N=0, SHALL go directly to ROUND. Otherwise go to SHIFT with a 5-bit counter = N.
REQ-014 SHIFT SHALL shift 1 bit per cycle, decrementing the counter, and exit to ROUND when it reaches 0.
REQ-015 Right shifts SHALL maintain guard bit and sticky OR of all bits beyond guard.
REQ-016 ROUND (one cycle) SHALL apply r_mode to the magnitude using guard/sticky and sign:
- RNE: ties to even.
- RTZ: truncate.
- RDN: increment if negative and inexact.
- RUP: increment if positive and inexact.
- RMM: increment if guard set.
REQ-017 ROUND SHALL negate the magnitude if sign=1, set inexact = guard|sticky (0 for specials), register outputs, and enter DONE.
REQ-018 Latency: out_valid SHALL rise N+1 cycles after the transfer edge (1 cycle for specials/N=0).
REQ-019 In DONE, out_valid=1 and int_out/invalid/inexact SHALL stay stable until out_ready=1. That cycle SHALL return to IDLE; no same-cycle accept.
REQ-020 -0.0 and +0.0 SHALL yield 0 with no flags. A negative result rounding to magnitude 0 SHALL yield 0x00000000.
REQ-021 in_valid while busy SHALL be ignored; fp_in/r_mode changes after transfer SHALL not affect the result.

Reset
REQ-022 Reset asserted SHALL force IDLE and clear the counter and datapath registers. Outputs SHALL be in_ready=1 (after deassert), out_valid=0, int_out=0, invalid=0, inexact=0.
REQ-023 Reset mid-SHIFT/ROUND/DONE SHALL abandon the operation without emitting a result.

Configuration
REQ-024 Macro F2I_UNSIGNED_EN defined SHALL add input unsigned_op (1 bit, latched at transfer):
- Range is 0..0xFFFFFFFF; left shift allowed up to e=158 (N<=8).
- NaN/+Inf/+overflow → 0xFFFFFFFF, invalid.
- Negative with nonzero rounded magnitude or -Inf → 0, invalid.
- Negative rounding to 0 → 0, inexact only.
REQ-025 Without F2I_UNSIGNED_EN, the port SHALL be absent and behaviour is signed only.

Verification
REQ-026 0x3FC00000 (1.5), RNE → 0x00000002, inexact=1, out_valid 24 cycles after transfer. RTZ → 0x00000001.
REQ-027 0x40200000 (2.5): RNE → 2; RMM → 3. 0xC0200000 RDN → 0xFFFFFFFD; all inexact=1.
REQ-028 0xCF000000 → 0x80000000, no flags. 0x4F000000 → 0x7FFFFFFF, invalid=1. 0xFF800000 → 0x80000000, invalid=1.
REQ-029 0x7FC00000 → 0x7FFFFFFF, invalid=1, out_valid 1 cycle after transfer. 0x80000000 → 0, no flags.
REQ-030 0x00000001 RUP → 1, inexact. 0x80000001 RDN → 0xFFFFFFFF, inexact. 0x80000001 RTZ → 0, inexact.
REQ-031 Hold out_ready=0 for 5 cycles → outputs stable, in_ready=0. Then assert rst_n=0 during SHIFT of a new op → out_valid=0 and int_out=0 immediately; after release in_ready=1.
